stream_mux_arb: RTL
===================

Name: stream_mux_arb

Overview:
Registered N-channel, WIDTH-bit selector with valid/ready handshaking. Successor to the datapath 2:1 selector, for places where several producers share one consumer across a clock boundary, e.g. writeback-source selection or memory-request merging. Two modes:
- Explicit select: channel chosen by a select input.
- Round-robin arbitration: fair rotation among requesting channels.
One output register stage.

Parameters:
WIDTH, 32, data width per channel
CHANNELS, 4, number of input channels (2..16)
SEL_W, 2, select/channel-index width; must satisfy 2**SEL_W >= CHANNELS
MODE, 0, 0 = explicit select via sel, 1 = round-robin arbitration (sel ignored)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  CHANNELS  channel i has data
in_ready  output  CHANNELS  channel i transfer accepted this cycle when in_valid[i] & in_ready[i]
sel  input  SEL_W  requested channel (MODE 0 only)
out_data  output  WIDTH  registered selected data
out_valid  output  1  out_data holds an untaken beat
out_ready  input  1  consumer accepts beat when out_valid & out_ready
out_chan  output  SEL_W  index of channel that produced out_data

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_chan=0, rr pointer=CHANNELS-1 (channel 0 has first priority).
- load = !out_valid | out_ready; output register may capture a new beat only when load=1.
- Grant (combinational, from current inputs and state):
  - MODE 0: grant = sel if sel < CHANNELS and in_valid[sel]; otherwise no grant. sel >= CHANNELS never grants and never asserts any in_ready.
  - MODE 1: search channels ptr+1, ptr+2, … modulo CHANNELS, wrapping; first with in_valid=1 is granted. No requester gives no grant.
- in_ready[i] = load & (grant valid) & (grant == i). At most one in_ready bit high per cycle. in_ready is never high for a non-granted channel.
- Transfer on clock edge when in_valid[g] & in_ready[g]:
  - out_data <= channel g data
  - out_chan <= g
  - out_valid <= 1
  - MODE 1: ptr <= g
- No transfer but out_valid & out_ready: out_valid <= 0. out_data and out_chan hold their last values.
- out_valid=1 & out_ready=0: output register, out_chan and ptr all hold. All in_ready=0 (backpressure).
- Simultaneous take and load in the same cycle: new beat replaces old. Full throughput of 1 beat/cycle with no bubble.
- Latency: input accepted at edge N appears on out_data/out_valid after edge N, i.e. 1 cycle.
- Fairness (MODE 1): with all channels continuously valid and out_ready=1, grants cycle 0,1,…,CHANNELS-1,0,… Worst-case wait is CHANNELS-1 transfers.
- Ptr wrap: ptr=CHANNELS-1 searches from 0. Non-power-of-two CHANNELS never grants an index >= CHANNELS.
- sel may change any cycle in MODE 0. It is sampled combinationally and has no effect on a beat already in the output register.
- Reset mid-burst: out_valid drops immediately (async). The in-flight beat is discarded. Producers see in_ready=0 while rst_n=0.

Test Plan:
- Reset: rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0000; after release (MODE 1) first grant is ch0.
- MODE 0 pass-through, WIDTH=32: sel=2, in_valid=0100, ch2 data=0xDEADBEEF, out_ready=1 -> in_ready=0100; next cycle out_data=0xDEADBEEF, out_chan=2, out_valid=1.
- MODE 0 invalid/absent: sel=1 with in_valid=1101 -> in_ready=0000, no beat. CHANNELS=3, sel=3 -> no grant ever.
- MODE 1 rotation: in_valid=1111 for 8 cycles, out_ready=1 -> out_chan sequence 0,1,2,3,0,1,2,3 with back-to-back out_valid=1.
- MODE 1 sparse: in_valid=1010 held -> out_chan alternates 1,3,1,3. Then ch1 drops -> 3,3,3.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> out_data, out_chan and ptr frozen, in_ready=0000. out_ready=1 -> beat taken and next grant loaded the same cycle.

Source files
------------

// File: rtl/stream_mux_arb.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_arb
// Description : Registered N-channel valid/ready stream selector. MODE 0
//               forwards the channel named by sel; MODE 1 arbitrates
//               round-robin among requesting channels. One output register
//               stage, full 1 beat/cycle throughput.
// Ports       : clk, rst_n              - clock, async active-low reset
//               in_data/in_valid/in_ready - CHANNELS producer streams,
//                                           channel i at [i*WIDTH +: WIDTH]
//               sel                      - requested channel (MODE 0 only)
//               out_data/out_valid/out_ready/out_chan - registered consumer
//                                           stream plus source channel index
// Revision    : 1.0 - initial release
// ============================================================================
module stream_mux_arb #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int MODE     = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_chan
);

    logic             w_load;
    logic             w_grant_vld;
    logic             w_xfer;
    logic [SEL_W-1:0] w_grant;
    logic [WIDTH-1:0] w_grant_data;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_chan;

    // Output register can take a new beat when empty or being drained.
    assign w_load = ~r_out_valid | out_ready;
    // rst_n gates the handshake so producers never see ready during reset.
    assign w_xfer = rst_n & w_load & w_grant_vld;

    generate
        if (MODE == 1) begin : g_rr
            logic [SEL_W-1:0]      r_ptr;
            logic [SEL_W:0]        w_start;
            logic [2*CHANNELS-1:0] w_dbl;
            logic [CHANNELS-1:0]   w_rot;
            logic [SEL_W:0]        w_offs;
            logic [SEL_W:0]        w_sum;
            logic                  w_unused_sel;

            assign w_unused_sel = ^sel;

            // Rotate the request vector so bit 0 is the channel after ptr;
            // the lowest set bit is then the winner's distance from ptr+1.
            assign w_start = {1'b0, r_ptr} + (SEL_W+1)'(1);
            assign w_dbl   = {in_valid, in_valid};
            assign w_rot   = CHANNELS'(w_dbl >> w_start);

            always_comb begin
                w_grant_vld = 1'b0;
                w_offs      = '0;
                // Descending scan: the last hit written is the lowest index.
                for (int j = CHANNELS - 1; j >= 0; j--) begin
                    if (w_rot[j]) begin
                        w_grant_vld = 1'b1;
                        w_offs      = (SEL_W+1)'(j);
                    end
                end
                // start <= CHANNELS and offs < CHANNELS, so one conditional
                // subtract is a full modulo and the result is always < CHANNELS.
                w_sum = w_start + w_offs;
                if (w_sum >= (SEL_W+1)'(CHANNELS)) begin
                    w_sum = w_sum - (SEL_W+1)'(CHANNELS);
                end
                w_grant = w_sum[SEL_W-1:0];
            end

            // Reset to the last channel so channel 0 has first priority.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ptr <= SEL_W'(CHANNELS - 1);
                end else if (w_xfer) begin
                    r_ptr <= w_grant;
                end
            end
        end else begin : g_sel
            localparam int c_sel_span = 2**SEL_W;
            logic [c_sel_span-1:0] w_valid_ext;

            // Zero-extending in_valid to every encodable sel value makes an
            // out-of-range sel read a 0 request, so it can never grant.
            assign w_valid_ext = c_sel_span'(in_valid);
            assign w_grant     = sel;
            assign w_grant_vld = w_valid_ext[sel];
        end
    endgenerate

    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant == SEL_W'(i)) begin
                w_grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
            assign in_ready[gi] = w_xfer & (w_grant == SEL_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_grant_data;
            r_out_chan  <= w_grant;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

endmodule
`default_nettype wire
